// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   slot_t       : one shadow-pipeline entry {valid, rf_we, is_load, wR}
//   FWD_*        : operand source select encoding (RF / EX / MEM / WB)
//   REG_AW       : register index width
//   slot_writes(): true when a slot will write a given non-zero register
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              rf_we;
        logic              is_load;
        logic [REG_AW-1:0] wR;
    } slot_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // x0 is hard-wired zero, so a "write" to it never creates a dependency.
    function automatic logic slot_writes(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.rf_we & (s.wR == r) & (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding selector for one source operand.
// Ports:
//   rs       in  REG_AW  source register index
//   rs_used  in  1       instruction actually reads this operand
//   ex_slot  in  slot_t  shadow EX entry
//   mem_slot in  slot_t  shadow MEM entry
//   wb_slot  in  slot_t  shadow WB entry
//   sel      out 2       FWD_RF / FWD_EX / FWD_MEM / FWD_WB
// The youngest producer wins. A load in EX has no data yet, so it is skipped
// here (the hazard logic stalls for it) and the search continues in MEM/WB.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (rs_used) begin
            if (slot_writes(ex_slot, rs) && !ex_slot.is_load) begin
                sel = FWD_EX;
            end else if (slot_writes(mem_slot, rs)) begin
                sel = FWD_MEM;
            end else if (slot_writes(wb_slot, rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks in-flight destination registers in a shadow EX/MEM/WB pipeline and
// produces stall/flush controls for IF/ID and ID/EX plus forwarding selects.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ext_stall                freeze whole pipeline (memory/bus not ready)
//   id_valid .. id_wR        decoded fields of the instruction in ID
//   ex_br_taken              EX resolved a taken branch/jump
//   pc_stall, ifid_stall     hold PC / IF/ID
//   ifid_flush, idex_flush   bubble IF/ID / ID/EX on next edge
//   fwd_a_sel, fwd_b_sel     rD1 / rD2 source select
//   stall_cnt, flush_cnt     saturating load-use stall / branch flush counters
// Control priority: ext_stall > taken branch > load-use.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_rf_we,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_wR,
    input  logic              ex_br_taken,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;
    slot_t id_slot;

    logic lu;
    logic br;

    // ID fields squashed to an empty slot when ID holds no real instruction.
    always_comb begin
        id_slot = '0;
        if (id_valid) begin
            id_slot.valid   = 1'b1;
            id_slot.rf_we   = id_rf_we;
            id_slot.is_load = id_is_load;
            id_slot.wR      = id_wR;
        end
    end

    assign lu = id_valid & ex_q.is_load &
                ((id_rs1_used & slot_writes(ex_q, id_rs1)) |
                 (id_rs2_used & slot_writes(ex_q, id_rs2)));

    // A taken indication with nothing valid in EX is spurious.
    assign br = ex_br_taken & ex_q.valid;

    // Controls are forced low while reset is held so the surrounding pipeline
    // registers never see a stall or flush request during reset.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            if (ext_stall) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else if (br) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // Shadow pipeline; a held branch stays in EX across ext_stall and fires
    // on the first free cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!ext_stall) begin
            ex_q  <= idex_flush ? '0 : id_slot;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!ext_stall) begin
            if (br) begin
                if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
            end else if (lu) begin
                if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    fwd_sel u_fwd_a (
        .rs       (id_rs1),
        .rs_used  (id_rs1_used),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_a_sel)
    );

    fwd_sel u_fwd_b (
        .rs       (id_rs2),
        .rs_used  (id_rs2_used),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_b_sel)
    );

endmodule
